// File: rtl/traffic_gen_client.sv
// NoC traffic source/sink for one torus router port: an LFSR-driven packet generator
// regulated by a token bucket, plus receive/misroute statistics for delivered packets.
module traffic_gen_client #(
  parameter int          NUM_VC    = 2,
  parameter int          VC_W      = 3,
  parameter int          X_W       = 2,
  parameter int          Y_W       = 2,
  parameter int          X         = 0,
  parameter int          Y         = 0,
  parameter int          D_W       = 28,
  parameter int          N_PACKETS = 128,
  parameter int          SIGMA     = 3,
  parameter int          RATE      = 20,
  parameter int          MODE      = 0,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i_ack,
  output logic             i_v,
  output logic [VC_W-1:0]  i_vc,
  output logic [X_W-1:0]   i_x,
  output logic [Y_W-1:0]   i_y,
  output logic [D_W-1:0]   i_data,
  input  logic             o_v,
  input  logic [X_W-1:0]   o_x,
  input  logic [Y_W-1:0]   o_y,
  input  logic [D_W-1:0]   o_data,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] recv_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done
);

  localparam logic [X_W-1:0]   XC        = X[X_W-1:0];
  localparam logic [Y_W-1:0]   YC        = Y[Y_W-1:0];
  localparam logic [31:0]      N_PKT     = N_PACKETS;
  localparam int               TOK_W     = $clog2(SIGMA + 1) + 1;
  localparam int               RC_W      = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [15:0]      LFSR_INIT = (SEED == 16'd0) ? 16'd1 : SEED;

  typedef enum logic [1:0] {IDLE, SEND, DONE_S} state_t;

  state_t           state;
  logic [TOK_W-1:0] tokens;
  logic [RC_W-1:0]  rcnt;
  logic [VC_W-1:0]  rr;
  logic [31:0]      seq;
  logic [15:0]      lfsr;

  logic             refill;
  logic             consume;
  logic [TOK_W:0]   tok_sum;
  logic [TOK_W-1:0] tok_next;
  logic [15:0]      lfsr_next;
  logic [X_W-1:0]   rnd_x, nb_x, dst_x;
  logic [Y_W-1:0]   rnd_y, dst_y;
  logic [D_W-1:0]   pkt_data;
  logic             unused_data;

  assign unused_data = ^o_data;

  // Handshake: i_v stays high with all i_* fields frozen until the router raises
  // i_ack in a cycle where i_v is high; that edge retires the packet (and may
  // load the next one with no bubble). i_ack while i_v is low has no effect.
  always_comb begin
    refill   = (rcnt == RC_W'(RATE - 1));
    consume  = en && (tokens != '0) && (seq < N_PKT) &&
               ((state == IDLE) || ((state == SEND) && i_ack));
    tok_sum  = {1'b0, tokens} + (TOK_W+1)'(refill) - (TOK_W+1)'(consume);
    tok_next = (tok_sum > (TOK_W+1)'(SIGMA)) ? TOK_W'(SIGMA) : tok_sum[TOK_W-1:0];

    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Random destination never targets this node: flip x LSB on a self-hit.
    rnd_x = lfsr[X_W-1:0];
    rnd_y = lfsr[X_W+Y_W-1:X_W];
    if ((rnd_x == XC) && (rnd_y == YC)) rnd_x[0] = ~rnd_x[0];
    nb_x = XC + X_W'(1);

    dst_x = nb_x;
    dst_y = YC;
    case (MODE)
      0: begin
        dst_x = rnd_x;
        dst_y = rnd_y;
      end
      1: begin
        if (X != Y) begin
          dst_x = X_W'(YC);
          dst_y = Y_W'(XC);
        end
      end
      default: ;
    endcase

    pkt_data                     = '0;
    pkt_data[D_W-1 -: X_W]       = XC;
    pkt_data[D_W-X_W-1 -: Y_W]   = YC;
    pkt_data[CNT_W-1:0]          = seq[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tokens   <= TOK_W'(SIGMA);
      rcnt     <= '0;
      rr       <= '0;
      seq      <= '0;
      lfsr     <= LFSR_INIT;
      i_v      <= 1'b0;
      i_vc     <= '0;
      i_x      <= '0;
      i_y      <= '0;
      i_data   <= '0;
      sent_cnt <= '0;
      recv_cnt <= '0;
      err_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      rcnt   <= refill ? '0 : rcnt + RC_W'(1);
      tokens <= tok_next;

      if (consume) begin
        state  <= SEND;
        i_v    <= 1'b1;
        i_vc   <= rr;
        i_x    <= dst_x;
        i_y    <= dst_y;
        i_data <= pkt_data;
        rr     <= (rr == VC_W'(NUM_VC - 1)) ? '0 : rr + VC_W'(1);
        seq    <= seq + 32'd1;
        lfsr   <= lfsr_next;
      end else if ((state == SEND) && i_ack) begin
        i_v <= 1'b0;
        if (seq >= N_PKT) begin
          state <= DONE_S;
          done  <= 1'b1;
        end else begin
          state <= IDLE;
        end
      end

      if (i_v && i_ack && (sent_cnt != CNT_MAX)) sent_cnt <= sent_cnt + CNT_W'(1);
      if (o_v && (recv_cnt != CNT_MAX)) recv_cnt <= recv_cnt + CNT_W'(1);
      if (o_v && ((o_x != XC) || (o_y != YC)) && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_traffic_gen_client.sv
// Directed bench for traffic_gen_client: three instances (neighbour mode with long run,
// random mode seed 1 with 4 packets, random mode with a second seed) on one clock.
module tb_traffic_gen_client;

  localparam int VC_W  = 3;
  localparam int X_W   = 2;
  localparam int Y_W   = 2;
  localparam int D_W   = 28;
  localparam int CNT_W = 16;
  localparam logic [D_W-1:0] A_BASE = 28'h600_0000;  // X=1, Y=2 in the top bits

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic rst_a, en_a, ack_a, ov_a;
  logic [X_W-1:0] ox_a;
  logic [Y_W-1:0] oy_a;
  logic [D_W-1:0] od_a;
  logic iv_a, done_a;
  logic [VC_W-1:0] vc_a;
  logic [X_W-1:0] x_a;
  logic [Y_W-1:0] y_a;
  logic [D_W-1:0] data_a;
  logic [CNT_W-1:0] sent_a, recv_a, err_a;

  logic rst_b, en_b, ack_b, ack_c, ov_bc;
  logic [X_W-1:0] ox_bc;
  logic [Y_W-1:0] oy_bc;
  logic [D_W-1:0] od_bc;
  logic iv_b, done_b, iv_c, done_c;
  logic [VC_W-1:0] vc_b, vc_c;
  logic [X_W-1:0] x_b, x_c;
  logic [Y_W-1:0] y_b, y_c;
  logic [D_W-1:0] data_b, data_c;
  logic [CNT_W-1:0] sent_b, recv_b, err_b, sent_c, recv_c, err_c;

  traffic_gen_client #(.NUM_VC(2), .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .X(1), .Y(2),
    .D_W(D_W), .N_PACKETS(16), .SIGMA(3), .RATE(20), .MODE(2), .SEED(16'hACE1), .CNT_W(CNT_W))
  dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .i_ack(ack_a), .i_v(iv_a), .i_vc(vc_a), .i_x(x_a),
    .i_y(y_a), .i_data(data_a), .o_v(ov_a), .o_x(ox_a), .o_y(oy_a), .o_data(od_a),
    .sent_cnt(sent_a), .recv_cnt(recv_a), .err_cnt(err_a), .done(done_a)
  );

  traffic_gen_client #(.NUM_VC(2), .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .X(0), .Y(0),
    .D_W(D_W), .N_PACKETS(4), .SIGMA(3), .RATE(20), .MODE(0), .SEED(16'h0001), .CNT_W(CNT_W))
  dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .i_ack(ack_b), .i_v(iv_b), .i_vc(vc_b), .i_x(x_b),
    .i_y(y_b), .i_data(data_b), .o_v(ov_bc), .o_x(ox_bc), .o_y(oy_bc), .o_data(od_bc),
    .sent_cnt(sent_b), .recv_cnt(recv_b), .err_cnt(err_b), .done(done_b)
  );

  traffic_gen_client #(.NUM_VC(2), .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .X(0), .Y(0),
    .D_W(D_W), .N_PACKETS(4), .SIGMA(3), .RATE(20), .MODE(0), .SEED(16'h00A7), .CNT_W(CNT_W))
  dut_c (
    .clk(clk), .rst(rst_b), .en(en_b), .i_ack(ack_c), .i_v(iv_c), .i_vc(vc_c), .i_x(x_c),
    .i_y(y_c), .i_data(data_c), .o_v(ov_bc), .o_x(ox_bc), .o_y(oy_bc), .o_data(od_bc),
    .sent_cnt(sent_c), .recv_cnt(recv_c), .err_cnt(err_c), .done(done_c)
  );

  task automatic test_reset();
    rst_a = 1; rst_b = 1; en_a = 0; en_b = 0;
    ack_a = 0; ack_b = 0; ack_c = 0;
    ov_a = 0; ox_a = '0; oy_a = '0; od_a = '0;
    ov_bc = 0; ox_bc = '0; oy_bc = '0; od_bc = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({iv_a, vc_a, x_a, y_a, data_a, done_a} !== '0) begin
      bad++; $display("FAIL reset_a_pkt: got %0h want 0", {iv_a, vc_a, x_a, y_a, data_a, done_a});
    end
    total++;
    if ({sent_a, recv_a, err_a} !== '0) begin
      bad++; $display("FAIL reset_a_cnt: got %0h want 0", {sent_a, recv_a, err_a});
    end
    total++;
    if ({iv_b, vc_b, x_b, y_b, data_b, done_b, sent_b, recv_b, err_b} !== '0) begin
      bad++; $display("FAIL reset_b: got %0h want 0", {iv_b, vc_b, x_b, y_b, data_b, done_b, sent_b});
    end
    total++;
    if ({iv_c, vc_c, x_c, y_c, data_c, done_c, sent_c, recv_c, err_c} !== '0) begin
      bad++; $display("FAIL reset_c: got %0h want 0", {iv_c, vc_c, x_c, y_c, data_c, done_c, sent_c});
    end
  endtask

  // Instances b and c: 3-packet burst, one more after the first refill, then done.
  task automatic test_done_lfsr();
    int nb = 0;
    int nc = 0;
    int exp_cyc[4] = '{0, 1, 2, 20};
    int exp_cx[4]  = '{3, 3, 1, 0};
    int exp_cy[4]  = '{1, 0, 2, 1};
    logic [VC_W+X_W+Y_W+D_W-1:0] got, want;
    rst_b = 0; en_b = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (iv_b) begin
        got  = {vc_b, x_b, y_b, data_b};
        want = {VC_W'(nb % 2), 2'd1, 2'd0, D_W'(nb)};
        total++;
        if (nb >= 4 || cyc != exp_cyc[nb] || got !== want) begin
          bad++;
          $display("FAIL lfsr_b_pkt%0d: cyc=%0d fields=%0h want cyc=%0d fields=%0h",
                   nb, cyc, got, (nb < 4) ? exp_cyc[nb] : -1, want);
        end
        nb++;
      end
      if (iv_c) begin
        got  = {vc_c, x_c, y_c, data_c};
        want = (nc < 4) ? {VC_W'(nc % 2), X_W'(exp_cx[nc]), Y_W'(exp_cy[nc]), D_W'(nc)} : '0;
        total++;
        if (nc >= 4 || cyc != exp_cyc[nc] || got !== want) begin
          bad++;
          $display("FAIL lfsr_c_pkt%0d: cyc=%0d fields=%0h want cyc=%0d fields=%0h",
                   nc, cyc, got, (nc < 4) ? exp_cyc[nc] : -1, want);
        end
        nc++;
      end
      if (cyc == 20) begin
        total++;
        if (done_b !== 1'b0) begin
          bad++; $display("FAIL done_early: got %0b want 0", done_b);
        end
      end
      if (cyc == 21) begin
        total++;
        if (done_b !== 1'b1 || sent_b !== 16'd4) begin
          bad++; $display("FAIL done_after_last_ack: done=%0b sent=%0d want 1 4", done_b, sent_b);
        end
      end
      ack_b = iv_b;
      ack_c = iv_c;
    end
    total++;
    if (nb != 4 || nc != 4 || done_b !== 1'b1 || done_c !== 1'b1 || sent_c !== 16'd4) begin
      bad++;
      $display("FAIL done_sticky: nb=%0d nc=%0d done_b=%0b done_c=%0b sent_c=%0d want 4 4 1 1 4",
               nb, nc, done_b, done_c, sent_c);
    end
  endtask

  task automatic test_burst_rate();
    int n = 0;
    int exp_cyc[5] = '{0, 1, 2, 20, 40};
    logic [VC_W+X_W+Y_W+D_W-1:0] got, want;
    rst_a = 0; en_a = 1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (iv_a) begin
        got  = {vc_a, x_a, y_a, data_a};
        want = {VC_W'(n % 2), 2'd2, 2'd2, A_BASE | D_W'(n)};
        total++;
        if (n >= 5 || cyc != exp_cyc[n] || got !== want) begin
          bad++;
          $display("FAIL burst_pkt%0d: cyc=%0d fields=%0h want cyc=%0d fields=%0h",
                   n, cyc, got, (n < 5) ? exp_cyc[n] : -1, want);
        end
        n++;
      end
      ack_a = iv_a;
    end
    total++;
    if (n != 5 || sent_a !== 16'd5) begin
      bad++; $display("FAIL burst_count: pkts=%0d sent=%0d want 5 5", n, sent_a);
    end
  endtask

  task automatic test_hold();
    logic [VC_W+X_W+Y_W+D_W-1:0] held;
    int waited = 0;
    logic moved = 1'b0;
    ack_a = 0;
    while (!iv_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    held = {vc_a, x_a, y_a, data_a};
    total++;
    if (!iv_a || held !== {3'd1, 2'd2, 2'd2, A_BASE | 28'd5}) begin
      bad++; $display("FAIL hold_first: iv=%0b fields=%0h want 1 %0h", iv_a, held,
                      {3'd1, 2'd2, 2'd2, A_BASE | 28'd5});
    end
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (!iv_a || {vc_a, x_a, y_a, data_a} !== held) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++; $display("FAIL hold_stable: fields changed to %0h want %0h", {vc_a, x_a, y_a, data_a}, held);
    end
    ack_a = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (k < 3) begin
        if (!iv_a || {vc_a, data_a} !== {VC_W'((6 + k) % 2), A_BASE | D_W'(6 + k)}) begin
          bad++; $display("FAIL hold_burst%0d: iv=%0b vc=%0d data=%0h want 1 %0d %0h", k, iv_a,
                          vc_a, data_a, (6 + k) % 2, A_BASE | D_W'(6 + k));
        end
      end else if (iv_a !== 1'b0 || sent_a !== 16'd9) begin
        bad++; $display("FAIL hold_burst_end: iv=%0b sent=%0d want 0 9", iv_a, sent_a);
      end
      ack_a = iv_a;
    end
  endtask

  task automatic test_recv();
    int waited = 0;
    logic [X_W-1:0] xs[9] = '{2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    while (!iv_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    ack_a = 1; ov_a = 1; ox_a = 2'd0; oy_a = 2'd2; od_a = 28'h123;
    @(negedge clk);
    total++;
    if ({sent_a, recv_a, err_a} !== {16'd10, 16'd1, 16'd1}) begin
      bad++; $display("FAIL recv_with_ack: sent=%0d recv=%0d err=%0d want 10 1 1", sent_a, recv_a, err_a);
    end
    for (int i = 0; i < 9; i++) begin
      ov_a = 1; ox_a = xs[i]; oy_a = 2'd2; od_a = D_W'(i);
      @(negedge clk);
    end
    ov_a = 0; ack_a = 0;
    total++;
    if ({sent_a, recv_a, err_a} !== {16'd10, 16'd10, 16'd3}) begin
      bad++; $display("FAIL recv_counts: sent=%0d recv=%0d err=%0d want 10 10 3", sent_a, recv_a, err_a);
    end
  endtask

  task automatic test_en_low();
    int waited = 0;
    logic dropped = 1'b0;
    logic leaked = 1'b0;
    while (!iv_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    en_a = 0;
    repeat (5) begin
      @(negedge clk);
      if (!iv_a) dropped = 1'b1;
    end
    ack_a = 1;
    @(negedge clk);
    ack_a = 0;
    total++;
    if (dropped || iv_a !== 1'b0 || sent_a !== 16'd11) begin
      bad++; $display("FAIL en_low_inflight: dropped=%0b iv=%0b sent=%0d want 0 0 11", dropped, iv_a, sent_a);
    end
    repeat (60) begin
      @(negedge clk);
      if (iv_a) leaked = 1'b1;
    end
    total++;
    if (leaked) begin
      bad++; $display("FAIL en_low_quiet: packet issued while en=0, want none");
    end
    en_a = 1;
    @(negedge clk);
    total++;
    if (!iv_a || {vc_a, data_a} !== {3'd1, A_BASE | 28'd11}) begin
      bad++; $display("FAIL en_resume: iv=%0b vc=%0d data=%0h want 1 1 %0h", iv_a, vc_a, data_a,
                      A_BASE | 28'd11);
    end
  endtask

  task automatic test_rst_mid();
    rst_a = 1; ack_a = 0;
    @(negedge clk);
    total++;
    if ({iv_a, vc_a, x_a, y_a, data_a, done_a, sent_a, recv_a, err_a} !== '0) begin
      bad++; $display("FAIL rst_mid: iv=%0b sent=%0d recv=%0d err=%0d data=%0h want all 0",
                      iv_a, sent_a, recv_a, err_a, data_a);
    end
    rst_a = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (k < 3) begin
        if (!iv_a || {vc_a, data_a} !== {VC_W'(k % 2), A_BASE | D_W'(k)}) begin
          bad++; $display("FAIL rst_burst%0d: iv=%0b vc=%0d data=%0h want 1 %0d %0h", k, iv_a, vc_a,
                          data_a, k % 2, A_BASE | D_W'(k));
        end
      end else if (iv_a !== 1'b0 || sent_a !== 16'd3) begin
        bad++; $display("FAIL rst_burst_end: iv=%0b sent=%0d want 0 3", iv_a, sent_a);
      end
      ack_a = iv_a;
    end
  endtask

  initial begin
    test_reset();
    test_done_lfsr();
    test_burst_rate();
    test_hold();
    test_recv();
    test_en_low();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
